// File: rtl/rx_frame_checker_pkg.sv
// Shared Ethernet RX constants, status bundle and small helpers for rx_frame_checker.
// Optional counters in the top level are enabled by defining RX_CHK_CNT_EN.
package rx_frame_checker_pkg;

  localparam int          ETH_MIN_FRAME     = 64;
  localparam int          ETH_MAX_FRAME     = 1522;
  localparam int          ETH_LEN_WIDTH     = 11;
  localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE   = 32'hC704DD7B;

  typedef struct packed {
    logic [ETH_LEN_WIDTH-1:0] len;
    logic                     crc_err;
    logic                     runt;
    logic                     giant;
    logic                     line_err;
  } rx_chk_stat_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rx_frame_checker_crc32_d8.sv
// Combinational CRC-32 step over one byte, LSB-first (reflected 0x04C11DB7).
module crc32_d8
  import rx_frame_checker_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] POLY_REFL = reflect32(ETH_CRC_POLY);

  logic [31:0] c;

  always_comb begin
    // NOTE: blocking '=' is right here: c is scratch, rewritten on every loop pass within one evaluation.
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/rx_frame_checker.sv
// RX byte stage: strips preamble/SFD, checks CRC and length, forwards payload without FCS
// and emits one status word per frame. Define RX_CHK_CNT_EN to add saturating frame counters.
module rx_frame_checker
  import rx_frame_checker_pkg::*;
#(
  parameter int MIN_FRAME = ETH_MIN_FRAME,
  parameter int MAX_FRAME = ETH_MAX_FRAME,
  parameter int LEN_WIDTH = ETH_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef RX_CHK_CNT_EN
  input  logic                 cnt_clr,
  output logic [31:0]          frames_ok_cnt,
  output logic [31:0]          crc_err_cnt,
  output logic [31:0]          runt_cnt,
  output logic [31:0]          giant_cnt,
`endif
  input  logic                 in_act,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  input  logic                 in_err,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 stat_valid,
  output logic [LEN_WIDTH-1:0] stat_len,
  output logic                 stat_crc_err,
  output logic                 stat_runt,
  output logic                 stat_giant,
  output logic                 stat_line_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_DROP = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [31:0] RESIDUE_REFL = reflect32(ETH_CRC_RESIDUE);

  logic [2:0]           state_q, state_d;
  logic                 act_q, act_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, len_inc;
  logic [31:0]          crc_q, crc_d, crc_next;
  logic [3:0][7:0]      buf_q, buf_d;
  logic [2:0]           buf_cnt_q, buf_cnt_d;
  logic                 line_err_q, line_err_d;
  logic                 giant_q, giant_d;
  logic                 sof_pend_q, sof_pend_d;
  logic                 out_valid_q, out_valid_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 out_sof_q, out_sof_d;
  logic                 stat_valid_q, stat_valid_d;
  rx_chk_stat_t         stat_q, stat_d;

  logic accept;
  logic frame_end;

  assign accept    = in_valid & in_act;
  assign len_inc   = (&len_q) ? len_q : len_q + LEN_WIDTH'(1);
  assign frame_end = ~in_act & ((state_q == S_PRE) | (state_q == S_DATA) | (state_q == S_DROP));

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (in_data),
    .crc_o  (crc_next)
  );

  always_comb begin
    state_d      = state_q;
    act_d        = in_act;
    len_d        = len_q;
    crc_d        = crc_q;
    buf_d        = buf_q;
    buf_cnt_d    = buf_cnt_q;
    line_err_d   = line_err_q;
    giant_d      = giant_q;
    sof_pend_d   = sof_pend_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_sof_d    = 1'b0;
    stat_valid_d = 1'b0;
    stat_d       = stat_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_act && !act_q) begin
          state_d    = S_PRE;
          len_d      = '0;
          crc_d      = ETH_CRC_INIT;
          buf_cnt_d  = '0;
          line_err_d = 1'b0;
          giant_d    = 1'b0;
          sof_pend_d = 1'b1;
        end
      end
      S_PRE: begin
        if (!in_act) begin
          state_d = S_DONE;
        end else begin
          if (in_err) line_err_d = 1'b1;
          if (accept) begin
            if (in_data == ETH_SFD_BYTE) begin
              state_d = S_DATA;
            end else if (in_data != ETH_PREAMBLE_BYTE) begin
              line_err_d = 1'b1;
              state_d    = S_DROP;
            end
          end
        end
      end
      S_DATA: begin
        if (!in_act) begin
          state_d = S_DONE;
        end else begin
          if (in_err) line_err_d = 1'b1;
          if (accept) begin
            crc_d = crc_next;
            len_d = len_inc;
            if (int'(len_q) >= MAX_FRAME) begin
              giant_d = 1'b1;
              state_d = S_DROP;
            end else begin
              // The newest four bytes are held back: at frame end they are the FCS.
              buf_d = {buf_q[2:0], in_data};
              if (buf_cnt_q == 3'd4) begin
                out_valid_d = 1'b1;
                out_data_d  = buf_q[3];
                out_sof_d   = sof_pend_q;
                sof_pend_d  = 1'b0;
              end else begin
                buf_cnt_d = buf_cnt_q + 3'd1;
              end
            end
          end
        end
      end
      S_DROP: begin
        if (!in_act) begin
          state_d = S_DONE;
        end else begin
          if (in_err) line_err_d = 1'b1;
          if (accept) begin
            crc_d = crc_next;
            len_d = len_inc;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        // Forget the level seen here so an in_act rise during DONE is still taken as a start.
        act_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_end) begin
      stat_valid_d    = 1'b1;
      stat_d.len      = ETH_LEN_WIDTH'(len_q);
      stat_d.runt     = int'(len_q) < MIN_FRAME;
      stat_d.giant    = giant_q;
      stat_d.line_err = line_err_q | in_err;
      stat_d.crc_err  = (state_q == S_PRE) | (crc_q != RESIDUE_REFL);
    end
  end

  // act_q resets high so a frame already in flight when reset releases is ignored until in_act drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      act_q        <= 1'b1;
      len_q        <= '0;
      crc_q        <= ETH_CRC_INIT;
      buf_cnt_q    <= '0;
      line_err_q   <= 1'b0;
      giant_q      <= 1'b0;
      sof_pend_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sof_q    <= 1'b0;
      stat_valid_q <= 1'b0;
      stat_q       <= '0;
    end else begin
      // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
      state_q      <= state_d;
      act_q        <= act_d;
      len_q        <= len_d;
      crc_q        <= crc_d;
      buf_cnt_q    <= buf_cnt_d;
      line_err_q   <= line_err_d;
      giant_q      <= giant_d;
      sof_pend_q   <= sof_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sof_q    <= out_sof_d;
      stat_valid_q <= stat_valid_d;
      stat_q       <= stat_d;
    end
  end

  // NOTE: the byte buffer is plain storage qualified by buf_cnt_q, so it needs no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_sof       = out_sof_q;
  assign out_eof       = stat_valid_q;
  assign stat_valid    = stat_valid_q;
  assign stat_len      = LEN_WIDTH'(stat_q.len);
  assign stat_crc_err  = stat_q.crc_err;
  assign stat_runt     = stat_q.runt;
  assign stat_giant    = stat_q.giant;
  assign stat_line_err = stat_q.line_err;

`ifdef RX_CHK_CNT_EN
  logic frame_ok;
  assign frame_ok = ~(stat_q.crc_err | stat_q.runt | stat_q.giant | stat_q.line_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_ok_cnt <= '0;
      crc_err_cnt   <= '0;
      runt_cnt      <= '0;
      giant_cnt     <= '0;
    end else if (cnt_clr) begin
      frames_ok_cnt <= '0;
      crc_err_cnt   <= '0;
      runt_cnt      <= '0;
      giant_cnt     <= '0;
    end else if (stat_valid_q) begin
      if (frame_ok)       frames_ok_cnt <= sat_inc32(frames_ok_cnt);
      if (stat_q.crc_err) crc_err_cnt   <= sat_inc32(crc_err_cnt);
      if (stat_q.runt)    runt_cnt      <= sat_inc32(runt_cnt);
      if (stat_q.giant)   giant_cnt     <= sat_inc32(giant_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_rx_frame_checker.sv
// Scoreboard bench for rx_frame_checker: directed frames, expected bytes/status queued at issue time.
module tb_rx_frame_checker;

  localparam int MAXF = 1522;

  logic        clk;
  logic        rst_n;
  logic        in_act;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_err;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        stat_valid;
  logic [10:0] stat_len;
  logic        stat_crc_err;
  logic        stat_runt;
  logic        stat_giant;
  logic        stat_line_err;
`ifdef RX_CHK_CNT_EN
  logic        cnt_clr;
  logic [31:0] frames_ok_cnt;
  logic [31:0] crc_err_cnt;
  logic [31:0] runt_cnt;
  logic [31:0] giant_cnt;
`endif

  rx_frame_checker dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef RX_CHK_CNT_EN
    .cnt_clr       (cnt_clr),
    .frames_ok_cnt (frames_ok_cnt),
    .crc_err_cnt   (crc_err_cnt),
    .runt_cnt      (runt_cnt),
    .giant_cnt     (giant_cnt),
`endif
    .in_act        (in_act),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_err        (in_err),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_sof       (out_sof),
    .out_eof       (out_eof),
    .stat_valid    (stat_valid),
    .stat_len      (stat_len),
    .stat_crc_err  (stat_crc_err),
    .stat_runt     (stat_runt),
    .stat_giant    (stat_giant),
    .stat_line_err (stat_line_err)
  );

  typedef struct {
    int len;
    bit crc_err;
    bit runt;
    bit giant;
    bit line_err;
  } exp_stat_t;

  logic [8:0]  exp_bytes[$];
  exp_stat_t   exp_stats[$];
  logic [7:0]  body[$];
  int          n_vec = 0;
  int          n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serial-form reference CRC over the body, result complemented as transmitted FCS.
  function automatic logic [31:0] ref_fcs(input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ body[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic build_frame(input int total, input int seed);
    logic [31:0] fcs;
    body.delete();
    for (int i = 0; i < total - 4; i++) body.push_back(8'((i * 13 + seed) & 255));
    fcs = ref_fcs(total - 4);
    body.push_back(fcs[7:0]);
    body.push_back(fcs[15:8]);
    body.push_back(fcs[23:16]);
    body.push_back(fcs[31:24]);
  endtask

  task automatic expect_frame(input bit crc_bad, input bit line_bad);
    exp_stat_t s;
    int n;
    int fwd;
    n   = body.size();
    fwd = (n > MAXF) ? MAXF - 4 : n - 4;
    for (int i = 0; i < fwd; i++) exp_bytes.push_back({i == 0, body[i]});
    s.len      = (n > 2047) ? 2047 : n;
    s.crc_err  = crc_bad;
    s.runt     = n < 64;
    s.giant    = n > MAXF;
    s.line_err = line_bad;
    exp_stats.push_back(s);
  endtask

  task automatic put_byte(input logic [7:0] b, input bit e, input int gap);
    in_valid = 1'b1;
    in_data  = b;
    in_err   = e;
    tick();
    in_valid = 1'b0;
    in_err   = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_preamble(input int gap);
    for (int i = 0; i < 7; i++) put_byte(8'h55, 1'b0, gap);
    put_byte(8'hD5, 1'b0, gap);
  endtask

  task automatic send_frame(input int err_idx, input int gap);
    in_act = 1'b1;
    tick();
    send_preamble(gap);
    foreach (body[i]) put_byte(body[i], i == err_idx, gap);
    in_act = 1'b0;
    repeat (4) tick();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte or a status word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        check("byte_expected", 32'(exp_bytes.size() > 0), 1);
        if (exp_bytes.size() > 0) begin
          logic [8:0] e;
          e = exp_bytes.pop_front();
          check("out_data", out_data, e[7:0]);
          check("out_sof", out_sof, e[8]);
        end
      end else if (out_sof) begin
        check("sof_without_valid", out_sof, 0);
      end
      if (stat_valid || out_eof) begin
        check("eof_matches_stat", out_eof, stat_valid);
        check("stat_expected", 32'(exp_stats.size() > 0), 1);
        if (exp_stats.size() > 0) begin
          exp_stat_t s;
          s = exp_stats.pop_front();
          check("stat_len", stat_len, s.len);
          check("stat_crc_err", stat_crc_err, s.crc_err);
          check("stat_runt", stat_runt, s.runt);
          check("stat_giant", stat_giant, s.giant);
          check("stat_line_err", stat_line_err, s.line_err);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_sof"}, out_sof, 0);
    check({tag, "_out_eof"}, out_eof, 0);
    check({tag, "_stat_valid"}, stat_valid, 0);
    check({tag, "_stat_len"}, stat_len, 0);
    check({tag, "_stat_flags"}, {stat_crc_err, stat_runt, stat_giant, stat_line_err}, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_act   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_err   = 1'b0;
`ifdef RX_CHK_CNT_EN
    cnt_clr  = 1'b0;
`endif
    repeat (3) tick();
    check_idle_outputs("reset");
    check("reset_out_data", out_data, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Good 64-byte frame, strobe every other cycle.
    build_frame(64, 1);
    expect_frame(1'b0, 1'b0);
    send_frame(-1, 1);

    // Same frame with one payload bit flipped.
    build_frame(64, 1);
    body[10] = body[10] ^ 8'h04;
    expect_frame(1'b1, 1'b0);
    send_frame(-1, 0);

    // 40-byte runt with good FCS.
    build_frame(40, 7);
    expect_frame(1'b0, 1'b0);
    send_frame(-1, 0);

    // 1600-byte giant: forwarding stops at MAX_FRAME, CRC keeps running.
    build_frame(1600, 3);
    expect_frame(1'b0, 1'b0);
    send_frame(-1, 0);

    // Bad preamble byte, then in_act held with no strobes.
    begin
      exp_stat_t s;
      s.len = 0; s.crc_err = 1; s.runt = 1; s.giant = 0; s.line_err = 1;
      exp_stats.push_back(s);
      in_act = 1'b1;
      tick();
      put_byte(8'h55, 1'b0, 0);
      put_byte(8'h57, 1'b0, 0);
      repeat (5) tick();
      in_act = 1'b0;
      repeat (4) tick();
    end

    // Good 64-byte frame with an rxer strobe on byte 20.
    build_frame(64, 9);
    expect_frame(1'b0, 1'b1);
    send_frame(20, 0);

`ifdef RX_CHK_CNT_EN
    check("cnt_ok_before_reset", frames_ok_cnt, 1);
    check("cnt_crc_before_reset", crc_err_cnt, 2);
    check("cnt_runt_before_reset", runt_cnt, 2);
    check("cnt_giant_before_reset", giant_cnt, 1);
`endif

    // Reset at byte 30 of a frame (8 preamble + 22 body bytes): 18 bytes already out, no status.
    build_frame(64, 5);
    for (int i = 0; i < 18; i++) exp_bytes.push_back({i == 0, body[i]});
    in_act = 1'b1;
    tick();
    send_preamble(0);
    for (int i = 0; i < 22; i++) put_byte(body[i], 1'b0, 0);
    repeat (2) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    for (int i = 22; i < 64; i++) put_byte(body[i], 1'b0, 0);
    in_act = 1'b0;
    repeat (4) tick();

    // Next good frame must report clean status.
    build_frame(64, 11);
    expect_frame(1'b0, 1'b0);
    send_frame(-1, 0);

`ifdef RX_CHK_CNT_EN
    check("cnt_ok_after_reset", frames_ok_cnt, 1);
    check("cnt_crc_after_reset", crc_err_cnt, 0);
    check("cnt_runt_after_reset", runt_cnt, 0);
    check("cnt_giant_after_reset", giant_cnt, 0);
`endif

    repeat (4) tick();
    check("bytes_left", exp_bytes.size(), 0);
    check("stats_left", exp_stats.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
